potential_adder_unit: RTL and testbench
=======================================

# potential_adder_unit

Single-precision floating-point membrane-potential adder for one LIF neuron in the SNN accelerator datapath. Each clock it adds the incoming synaptic weight to the decayed membrane potential and compares the sum against the neuron threshold. It registers the resulting potential and a spike flag. It sits between the potential-decay stage and the spike/accumulator logic; `clear` starts each 4-cycle timestep.

## Interface
- No parameters; all data is IEEE-754 binary32.
- `CLK`  input  1  — single clock, rising-edge active.
- `clear`  input  1  — synchronous, active-high reset; asserted for one cycle at timestep start.
- `v_threshold`  input  32  — firing threshold (binary32).
- `input_weight`  input  32  — accumulated synaptic weight (binary32).
- `decayed_potential`  input  32  — membrane potential after decay (binary32).
- `final_potential`  output  32  — registered updated potential (binary32).
- `spike`  output  1  — registered spike flag.

## Operation
- Sum: `S = input_weight + decayed_potential`, computed combinationally as a full binary32 add.
  - Align exponents; keep guard, round and sticky bits.
  - Add or subtract the mantissas, normalize, then round to nearest, ties to even.
- Special cases:
  - Denormal inputs are flushed to zero before the add; a denormal result is flushed to +0.
  - Exact cancellation (x + −x) gives +0.
  - Overflow gives ±infinity (0x7F800000 / 0xFF800000).
  - inf + finite = inf; +inf + −inf = NaN.
  - Any NaN input gives canonical NaN 0x7FC00000.
- Fire test: `fire = (S >= v_threshold)` as an IEEE ordered compare.
  - −0 equals +0.
  - If S or the threshold is NaN, fire = 0.
  - The threshold is denormal-flushed too.
- Register update on each rising CLK edge:
  - `clear`=1: `final_potential` <= 0x00000000, `spike` <= 0. `clear` overrides all other behaviour.
  - Otherwise, if fire: `spike` <= 1 and `final_potential` <= 0x00000000 (reset-to-zero after firing).
  - Otherwise: `spike` <= 0 and `final_potential` <= S.
- No internal accumulation state. Each cycle's result depends only on the inputs sampled at that edge.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput: one result per cycle; no handshake; inputs must be stable at the rising edge.
- Reset values: `final_potential` = 0x00000000, `spike` = 0, one edge after `clear` is sampled high.
- Before the first `clear`, outputs are undefined (X permitted).
- `spike` is a per-cycle level. It stays high on consecutive cycles for as long as the fire condition holds.
- `clear` and fire in the same cycle: `clear` wins, so the outputs are 0 / 0.
- `clear` deasserted: normal operation resumes on the next edge with no extra bubble.
- Timestep convention: `clear` is high for 1 of every 4 cycles. The block does not count cycles itself.

## Test plan
- Reset: `clear`=1 with any inputs → after the edge, `final_potential`=0x00000000 and `spike`=0; this also holds for inputs that would fire (clear priority).
- Sub-threshold:
  - Stimulus: weight 0x41200000 (10.0), decayed 0x40B00000 (5.5), threshold 0x41880000 (17.0).
  - Response: `final_potential`=0x41780000 (15.5), `spike`=0 one cycle later, held every cycle while the inputs are held.
- Equal-to-threshold fire:
  - Stimulus: weight 10.0 plus decayed 0x40E00000 (7.0), threshold 17.0.
  - Response: `spike`=1 and `final_potential`=0x00000000. Changing decayed back to 5.5 gives `spike`=0 and 0x41780000 on the next cycle.
- Cancellation and sign:
  - 0x41200000 + 0xC1200000 with threshold 17.0 → 0x00000000, `spike`=0.
  - Same sum with threshold 0xC0000000 (−2.0) → `spike`=1, `final_potential`=0.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000.
  - 0x3F800000 + 0x33800001 → 0x3F800001.
  - 0x3F800001 + 0x33800000 → 0x3F800002.
- Specials:
  - 0x7F7FFFFF + 0x7F7FFFFF with threshold 17.0 → fire: `spike`=1, `final_potential`=0.
  - 0x7FC00000 + 1.0 → `final_potential`=0x7FC00000, `spike`=0.
  - Denormal 0x00000001 + 0 → 0x00000000.

Source files
------------

// File: rtl/potential_adder_unit_if.sv
// potential_adder_unit_if
//   Data bundle of the LIF membrane-potential adder. The clock and the
//   timestep clear stay plain ports on the adder itself.
//   v_threshold       : firing threshold (binary32), driven by the master
//   input_weight      : accumulated synaptic weight (binary32), master
//   decayed_potential : membrane potential after decay (binary32), master
//   final_potential   : registered updated potential (binary32), slave
//   spike             : registered spike flag, slave
interface potential_adder_unit_if;
  logic [31:0] v_threshold;
  logic [31:0] input_weight;
  logic [31:0] decayed_potential;
  logic [31:0] final_potential;
  logic        spike;

  modport master (
    output v_threshold, input_weight, decayed_potential,
    input  final_potential, spike
  );

  modport slave (
    input  v_threshold, input_weight, decayed_potential,
    output final_potential, spike
  );
endinterface

// File: rtl/potential_adder_unit.sv
// potential_adder_unit
//   Adds the synaptic weight to the decayed membrane potential as a
//   binary32 add (round to nearest even, denormals flushed to zero),
//   compares the sum against the threshold and registers the new
//   potential and spike flag. One result per cycle, latency one cycle.
//   CLK   : rising-edge clock
//   clear : synchronous active-high clear, highest priority
//   bus   : slave side of potential_adder_unit_if (operands in, results out)
module potential_adder_unit (
  input  logic                         CLK,
  input  logic                         clear,
  potential_adder_unit_if.slave        bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Leading-zero count of a 27-bit value; returns 27 for zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  // Maps a non-NaN binary32 onto an unsigned key whose order matches the
  // numeric order. Denormals and -0 collapse onto +0 first.
  function automatic logic [31:0] ord_key(input logic [31:0] x);
    logic [31:0] c;
    c = (x[30:23] == 8'h00) ? 32'h0 : x;
    return c[31] ? ~c : (c | 32'h8000_0000);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a,
                                         input logic [31:0] b);
    logic              sa, sb, sl;
    logic [7:0]        ea, eb, el, es, ediff;
    logic [22:0]       fa, fb;
    logic [23:0]       ml, ms;
    logic [26:0]       xl, xs, nm;
    logic [53:0]       sh;
    logic [27:0]       acc;
    logic [4:0]        lz;
    logic signed [9:0] e;
    logic              round_up;
    logic [24:0]       mr;
    logic [31:0]       res;

    // NOTE: inside functions and always_comb, blocking '=' gives ordered,
    // step-by-step evaluation; state registers below use '<=' only.
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    sl = 1'b0; el = 8'h0; es = 8'h0; ml = 24'h0; ms = 24'h0;
    xl = 27'h0; xs = 27'h0; nm = 27'h0; sh = 54'h0; acc = 28'h0;
    lz = 5'h0; e = 10'sd0; round_up = 1'b0; mr = 25'h0; ediff = 8'h0;
    res = 32'h0;

    if (is_nan(a) || is_nan(b) ||
        (ea == 8'hFF && eb == 8'hFF && sa != sb)) begin
      res = QNAN;
    end else if (ea == 8'hFF) begin
      res = {sa, 8'hFF, 23'h0};
    end else if (eb == 8'hFF) begin
      res = {sb, 8'hFF, 23'h0};
    end else if (ea == 8'h00 && eb == 8'h00) begin
      res = {sa & sb, 31'h0};                 // denormals count as zero
    end else if (ea == 8'h00) begin
      res = b;
    end else if (eb == 8'h00) begin
      res = a;
    end else begin
      // Larger magnitude operand goes in the "l" slot.
      if ({ea, fa} >= {eb, fb}) begin
        sl = sa; el = ea; es = eb; ml = {1'b1, fa}; ms = {1'b1, fb};
      end else begin
        sl = sb; el = eb; es = ea; ml = {1'b1, fb}; ms = {1'b1, fa};
      end
      ediff = el - es;
      // Mantissa plus guard/round/sticky; bits shifted past the sticky
      // position are OR-ed into it.
      xl = {ml, 3'b000};
      sh = {ms, 3'b000, 27'h0} >> ediff;
      xs = (ediff > 8'd26) ? 27'd1 : {sh[53:28], sh[27] | (|sh[26:0])};
      e  = $signed({2'b00, el});

      if (sa == sb) begin
        acc = {1'b0, xl} + {1'b0, xs};
        if (acc[27]) begin
          nm = {acc[27:2], acc[1] | acc[0]};
          e  = e + 10'sd1;
        end else begin
          nm = acc[26:0];
        end
      end else begin
        acc = {1'b0, xl - xs};
        lz  = lzc27(acc[26:0]);
        nm  = acc[26:0] << lz;
        e   = e - $signed({5'b00000, lz});
      end

      if (acc == 28'h0) begin
        res = 32'h0;                          // exact cancellation is +0
      end else begin
        round_up = nm[2] & (nm[1] | nm[0] | nm[3]);
        mr = {1'b0, nm[26:3]} + {24'h0, round_up};
        if (mr[24]) begin
          mr = mr >> 1;
          e  = e + 10'sd1;
        end
        if (e >= 10'sd255)    res = {sl, 8'hFF, 23'h0};
        else if (e <= 10'sd0) res = 32'h0;    // denormal result flushed
        else                  res = {sl, e[7:0], mr[22:0]};
      end
    end
    return res;
  endfunction

  logic [31:0] w_sum;
  logic [31:0] w_threshold;
  logic        w_fire;
  logic [31:0] r_final_potential;
  logic        r_spike;

  assign w_sum       = fp_add(bus.input_weight, bus.decayed_potential);
  assign w_threshold = bus.v_threshold;
  assign w_fire      = !is_nan(w_sum) && !is_nan(w_threshold) &&
                       (ord_key(w_sum) >= ord_key(w_threshold));

  // NOTE: clear is sampled only on the clock edge (synchronous), so it
  // sits inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (clear) begin
      r_final_potential <= 32'h0;
      r_spike           <= 1'b0;
    end else if (w_fire) begin
      r_final_potential <= 32'h0;             // reset-to-zero after firing
      r_spike           <= 1'b1;
    end else begin
      r_final_potential <= w_sum;
      r_spike           <= 1'b0;
    end
  end

  assign bus.final_potential = r_final_potential;
  assign bus.spike           = r_spike;

endmodule

// File: tb/tb_potential_adder_unit.sv
module tb_potential_adder_unit;

  typedef struct packed {
    logic [31:0] fp;
    logic        spk;
  } exp_t;

  logic CLK = 1'b0;
  logic clear = 1'b0;

  potential_adder_unit_if bus ();

  potential_adder_unit dut (
    .CLK   (CLK),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    done     = 1'b0;

  localparam logic [31:0] F10  = 32'h4120_0000;
  localparam logic [31:0] F5_5 = 32'h40B0_0000;
  localparam logic [31:0] F7   = 32'h40E0_0000;
  localparam logic [31:0] F17  = 32'h4188_0000;

  task automatic check(input string nm, input logic [32:0] act,
                       input logic [32:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got potential=%h spike=%b, expected potential=%h spike=%b",
               nm, act[32:1], act[0], req[32:1], req[0]);
    end
  endtask

  // Applies one vector on the falling edge and records what the outputs
  // must show after the next rising edge.
  task automatic drive(input string nm, input logic clr, input logic [31:0] w,
                       input logic [31:0] d, input logic [31:0] t,
                       input logic [31:0] efp, input logic espk);
    exp_t x;
    @(negedge CLK);
    clear                 = clr;
    bus.input_weight      = w;
    bus.decayed_potential = d;
    bus.v_threshold       = t;
    x.fp  = efp;
    x.spk = espk;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  // Monitor: the block has no valid signal, so every cycle after a vector
  // was issued presents one result.
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t  x;
      string nm;
      x  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, {bus.final_potential, bus.spike}, {x.fp, x.spk});
    end
  end

  initial begin
    bus.input_weight      = 32'h0;
    bus.decayed_potential = 32'h0;
    bus.v_threshold       = 32'h0;

    drive("reset",          1'b1, F10, F5_5, F17, 32'h0, 1'b0);
    drive("clear_priority", 1'b1, F10, F7,   F17, 32'h0, 1'b0);
    drive("sub_threshold",  1'b0, F10, F5_5, F17, 32'h4178_0000, 1'b0);
    drive("sub_hold",       1'b0, F10, F5_5, F17, 32'h4178_0000, 1'b0);
    drive("equal_fire",     1'b0, F10, F7,   F17, 32'h0, 1'b1);
    drive("fire_hold",      1'b0, F10, F7,   F17, 32'h0, 1'b1);
    drive("unfire",         1'b0, F10, F5_5, F17, 32'h4178_0000, 1'b0);
    drive("cancel",         1'b0, F10, 32'hC120_0000, F17, 32'h0, 1'b0);
    drive("cancel_neg_thr", 1'b0, F10, 32'hC120_0000, 32'hC000_0000, 32'h0, 1'b1);
    drive("rne_tie_even",   1'b0, 32'h3F80_0000, 32'h3380_0000, F17, 32'h3F80_0000, 1'b0);
    drive("rne_above_tie",  1'b0, 32'h3F80_0000, 32'h3380_0001, F17, 32'h3F80_0001, 1'b0);
    drive("rne_tie_odd",    1'b0, 32'h3F80_0001, 32'h3380_0000, F17, 32'h3F80_0002, 1'b0);
    drive("overflow_fire",  1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, F17, 32'h0, 1'b1);
    drive("neg_overflow",   1'b0, 32'hFF7F_FFFF, 32'hFF7F_FFFF, F17, 32'hFF80_0000, 1'b0);
    drive("nan_input",      1'b0, 32'h7FC0_0000, 32'h3F80_0000, F17, 32'h7FC0_0000, 1'b0);
    drive("inf_minus_inf",  1'b0, 32'h7F80_0000, 32'hFF80_0000, F17, 32'h7FC0_0000, 1'b0);
    drive("inf_plus_one",   1'b0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h0, 1'b1);
    drive("denormal_flush", 1'b0, 32'h0000_0001, 32'h0, F17, 32'h0, 1'b0);
    drive("zero_vs_negzero",1'b0, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 1'b1);
    drive("denormal_thr",   1'b0, 32'h0, 32'h0, 32'h0000_0005, 32'h0, 1'b1);
    drive("sub_normalize",  1'b0, 32'h4040_0000, 32'hC000_0000, F17, 32'h3F80_0000, 1'b0);
    drive("neg_result",     1'b0, 32'h4000_0000, 32'hC040_0000, F17, 32'hBF80_0000, 1'b0);
    drive("nan_threshold",  1'b0, F10, F7, 32'h7FC0_0001, 32'h4188_0000, 1'b0);
    drive("clear_midrun",   1'b1, F10, F7,   F17, 32'h0, 1'b0);
    drive("resume",         1'b0, F10, F5_5, F17, 32'h4178_0000, 1'b0);

    @(negedge CLK);
    clear = 1'b0;
    repeat (3) @(negedge CLK);
    check("drain", {1'b0, 32'(exp_q.size())}, 33'h0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    if (!done) begin
      $display("FAIL watchdog: got no completion, expected completion within 50000 time units");
      $fatal(1, "timeout");
    end
  end

endmodule
